// File: rtl/led_scan_display.sv
// Multiplexed seven-segment scanner: hex decode, per-digit dp, leading-zero blanking, frame-synchronous update.
// Define BIN2BCD_EN to convert loaded binary values to decimal with a sequential double-dabble engine.
module led_scan_display #(
  parameter int DIGITS     = 8,
  parameter int SCAN_DIV   = 4,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                  clk_fs,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   disp_data,
  input  logic [DIGITS-1:0]     dp_mask,
  input  logic                  blank_lz,
  input  logic                  load,
  output logic [7:0]            seg_out,
  output logic [DIGITS-1:0]     dig_sel,
  output logic                  frame_done
);

  localparam int   DW  = 4 * DIGITS;
  localparam int   PW  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int   IW  = $clog2(DIGITS);
  localparam logic POL = (ACTIVE_LOW != 0);

  logic [PW-1:0]     presc_reg, presc_next;
  logic [IW-1:0]     idx_reg, idx_next;
  logic              frame_done_reg, frame_done_next;
  logic [DW-1:0]     hold_data_reg, shadow_data_reg;
  logic [DIGITS-1:0] hold_dp_reg, shadow_dp_reg;
  logic [7:0]        seg_reg, seg_next;
  logic [DIGITS-1:0] dig_reg, dig_next;

  // Scan position: prescaler inside the digit, digit index inside the frame.
  always_comb begin
    presc_next = presc_reg + 1'b1;
    idx_next   = idx_reg;
    if (presc_reg == PW'(SCAN_DIV - 1)) begin
      presc_next = '0;
      idx_next   = (idx_reg == IW'(DIGITS - 1)) ? '0 : idx_reg + 1'b1;
    end
    frame_done_next = (presc_next == PW'(SCAN_DIV - 1)) && (idx_next == IW'(DIGITS - 1));
  end

  always_ff @(posedge clk_fs or posedge rst) begin
    if (rst) begin
      presc_reg      <= '0;
      idx_reg        <= '0;
      frame_done_reg <= 1'b0;
    end else begin
      presc_reg      <= presc_next;
      idx_reg        <= idx_next;
      frame_done_reg <= frame_done_next;
    end
  end

  always_ff @(posedge clk_fs or posedge rst) begin
    if (rst) begin
      hold_dp_reg <= '0;
    end else if (load) begin
      hold_dp_reg <= dp_mask;
    end
  end

`ifdef BIN2BCD_EN
  localparam int            CW        = $clog2(DW);
  localparam logic [DW-1:0] BCD_NINES = {DIGITS{4'h9}};

  logic              conv_busy_reg;
  logic [CW-1:0]     conv_cnt_reg;
  logic [DW-1:0]     conv_bin_reg, conv_bcd_reg;
  logic              conv_ovf_reg;
  logic              pend_valid_reg;
  logic [DW-1:0]     pend_data_reg;
  logic [DW-1:0]     bcd_adj, bcd_step;
  logic              conv_last, ovf_any;

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_dabble
      assign bcd_adj[4*gi +: 4] = (conv_bcd_reg[4*gi +: 4] >= 4'd5) ?
                                  conv_bcd_reg[4*gi +: 4] + 4'd3 : conv_bcd_reg[4*gi +: 4];
    end
  endgenerate

  assign bcd_step  = {bcd_adj[DW-2:0], conv_bin_reg[DW-1]};
  assign ovf_any   = conv_ovf_reg | bcd_adj[DW-1];
  assign conv_last = (conv_cnt_reg == CW'(DW - 1));

  // A load arriving on the finishing cycle supersedes any older pending value.
  always_ff @(posedge clk_fs or posedge rst) begin
    if (rst) begin
      conv_busy_reg  <= 1'b0;
      conv_cnt_reg   <= '0;
      conv_bin_reg   <= '0;
      conv_bcd_reg   <= '0;
      conv_ovf_reg   <= 1'b0;
      pend_valid_reg <= 1'b0;
      pend_data_reg  <= '0;
      hold_data_reg  <= '0;
    end else if (conv_busy_reg) begin
      conv_bin_reg <= conv_bin_reg << 1;
      conv_bcd_reg <= bcd_step;
      conv_ovf_reg <= ovf_any;
      conv_cnt_reg <= conv_cnt_reg + 1'b1;
      if (conv_last) begin
        hold_data_reg <= ovf_any ? BCD_NINES : bcd_step;
        if (load || pend_valid_reg) begin
          conv_bin_reg   <= load ? disp_data : pend_data_reg;
          conv_bcd_reg   <= '0;
          conv_ovf_reg   <= 1'b0;
          conv_cnt_reg   <= '0;
          pend_valid_reg <= 1'b0;
        end else begin
          conv_busy_reg <= 1'b0;
        end
      end else if (load) begin
        pend_valid_reg <= 1'b1;
        pend_data_reg  <= disp_data;
      end
    end else if (load) begin
      conv_busy_reg <= 1'b1;
      conv_bin_reg  <= disp_data;
      conv_bcd_reg  <= '0;
      conv_ovf_reg  <= 1'b0;
      conv_cnt_reg  <= '0;
    end
  end
`else
  always_ff @(posedge clk_fs or posedge rst) begin
    if (rst) begin
      hold_data_reg <= '0;
    end else if (load) begin
      hold_data_reg <= disp_data;
    end
  end
`endif

  // Shadow only moves on the frame boundary so a frame never mixes two loads.
  always_ff @(posedge clk_fs or posedge rst) begin
    if (rst) begin
      shadow_data_reg <= '0;
      shadow_dp_reg   <= '0;
    end else if (frame_done_reg) begin
      shadow_data_reg <= hold_data_reg;
      shadow_dp_reg   <= hold_dp_reg;
    end
  end

  function automatic logic [6:0] glyph(input logic [3:0] nib);
    logic [6:0] g;
    case (nib)
      4'h0: g = 7'h3F;
      4'h1: g = 7'h06;
      4'h2: g = 7'h5B;
      4'h3: g = 7'h4F;
      4'h4: g = 7'h66;
      4'h5: g = 7'h6D;
      4'h6: g = 7'h7D;
      4'h7: g = 7'h07;
      4'h8: g = 7'h7F;
      4'h9: g = 7'h6F;
      4'hA: g = 7'h77;
      4'hB: g = 7'h7C;
      4'hC: g = 7'h39;
      4'hD: g = 7'h5E;
      4'hE: g = 7'h79;
      default: g = 7'h71;
    endcase
    return g;
  endfunction

  // upper_zero[k]: this nibble and every more significant one are zero.
  logic [DIGITS-1:0] upper_zero;
  genvar gz;
  generate
    for (gz = 0; gz < DIGITS; gz++) begin : g_upper_zero
      assign upper_zero[gz] = ~|shadow_data_reg[DW-1:4*gz];
    end
  endgenerate

  logic [3:0]        cur_nib;
  logic              cur_blank;
  logic [7:0]        seg_raw;
  logic [DIGITS-1:0] dig_onehot;

  always_comb begin
    cur_nib    = shadow_data_reg[{idx_reg, 2'b00} +: 4];
    cur_blank  = blank_lz && (idx_reg != '0) && upper_zero[idx_reg];
    seg_raw    = {shadow_dp_reg[idx_reg], cur_blank ? 7'h00 : glyph(cur_nib)};
    dig_onehot = {{(DIGITS-1){1'b0}}, 1'b1} << idx_reg;
    seg_next   = seg_raw ^ {8{POL}};
    dig_next   = dig_onehot ^ {DIGITS{POL}};
  end

  always_ff @(posedge clk_fs or posedge rst) begin
    if (rst) begin
      seg_reg <= {8{POL}};
      dig_reg <= {DIGITS{POL}};
    end else begin
      seg_reg <= seg_next;
      dig_reg <= dig_next;
    end
  end

  assign seg_out    = seg_reg;
  assign dig_sel    = dig_reg;
  assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_led_scan_display.sv
// Bench for led_scan_display: arithmetic scan/decode model checked every cycle, plus directed literal checks.
`timescale 1ns/1ps
module tb_led_scan_display;
  localparam int DIGITS     = 8;
  localparam int SCAN_DIV   = 4;
  localparam int ACTIVE_LOW = 1;
  localparam int P          = DIGITS * SCAN_DIV;

  logic        clk_fs = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] disp_data = '0;
  logic [7:0]  dp_mask = '0;
  logic        blank_lz = 1'b0;
  logic        load = 1'b0;
  logic [7:0]  seg_out;
  logic [7:0]  dig_sel;
  logic        frame_done;

  int   checks = 0;
  int   errors = 0;
  logic chk_en = 1'b0;

  always #5 clk_fs = ~clk_fs;

  led_scan_display #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .ACTIVE_LOW(ACTIVE_LOW)) dut (
    .clk_fs(clk_fs), .rst(rst), .disp_data(disp_data), .dp_mask(dp_mask),
    .blank_lz(blank_lz), .load(load), .seg_out(seg_out), .dig_sel(dig_sel),
    .frame_done(frame_done)
  );

  function automatic logic [6:0] glyph(input logic [3:0] n);
    logic [6:0] tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    return tbl[n];
  endfunction

  function automatic logic [31:0] to_bcd(input logic [31:0] v);
    longint unsigned x = v;
    logic [31:0] r = '0;
    if (x > 64'd99999999) return 32'h99999999;
    for (int i = 0; i < 8; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic [7:0] model_seg(input logic [31:0] data, input logic [7:0] dp,
                                           input int k, input logic blz);
    logic [7:0]  s;
    logic [31:0] above;
    above = data >> (4 * k);
    s = {dp[k], glyph(data[4*k +: 4])};
    if (blz && k > 0 && above == 32'd0) s[6:0] = 7'h00;
    return ~s;
  endfunction

  // Reference model: m_pos = clock edges since reset, modulo one frame.
  int          m_pos;
  logic [31:0] m_hold, m_sh;
  logic [7:0]  m_hdp, m_sdp;
  logic [7:0]  exp_seg, exp_dig;
  logic        exp_fd;
  int          conv_rem;
  logic [31:0] conv_val, pend_val;
  logic        pend_v;

  always @(posedge clk_fs or posedge rst) begin
    if (rst) begin
      m_pos <= 0; m_hold <= '0; m_sh <= '0; m_hdp <= '0; m_sdp <= '0;
      exp_seg <= 8'hFF; exp_dig <= 8'hFF; exp_fd <= 1'b0;
      conv_rem <= 0; conv_val <= '0; pend_val <= '0; pend_v <= 1'b0;
    end else begin
      exp_seg <= model_seg(m_sh, m_sdp, m_pos / SCAN_DIV, blank_lz);
      exp_dig <= ~(8'd1 << (m_pos / SCAN_DIV));
      exp_fd  <= (((m_pos + 1) % P) == P - 1);
      m_pos   <= (m_pos + 1) % P;
      if (m_pos == P - 1) begin
        m_sh  <= m_hold;
        m_sdp <= m_hdp;
      end
      if (load) m_hdp <= dp_mask;
`ifdef BIN2BCD_EN
      if (conv_rem != 0) begin
        if (conv_rem == 1) begin
          m_hold <= to_bcd(conv_val);
          if (load) begin
            conv_val <= disp_data; conv_rem <= P; pend_v <= 1'b0;
          end else if (pend_v) begin
            conv_val <= pend_val; conv_rem <= P; pend_v <= 1'b0;
          end else begin
            conv_rem <= 0;
          end
        end else begin
          conv_rem <= conv_rem - 1;
          if (load) begin pend_v <= 1'b1; pend_val <= disp_data; end
        end
      end else if (load) begin
        conv_val <= disp_data; conv_rem <= P;
      end
`else
      if (load) m_hold <= disp_data;
`endif
    end
  end

  int shown = 0;
  always @(negedge clk_fs) begin
    if (chk_en) begin
      checks++;
      if (seg_out !== exp_seg || dig_sel !== exp_dig || frame_done !== exp_fd) begin
        errors++;
        if (shown < 20)
          $display("FAIL cycle_model t=%0t seg=%h want %h dig=%h want %h fd=%b want %b",
                   $time, seg_out, exp_seg, dig_sel, exp_dig, frame_done, exp_fd);
        shown++;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, expv);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge clk_fs);
      #1;
    end
  endtask

  task automatic do_load(input logic [31:0] d, input logic [7:0] dp);
    disp_data = d; dp_mask = dp; load = 1'b1;
    $display("load data=%08h dp=%02h blank_lz=%0d t=%0t", d, dp, blank_lz, $time);
    cyc(1);
    load = 1'b0;
  endtask

  task automatic wait_fd(input string name);
    int n = 0;
    while (frame_done !== 1'b1 && n < 2 * P) begin
      cyc(1);
      n++;
    end
    checks++;
    if (frame_done !== 1'b1) begin
      errors++;
      $display("FAIL %s frame_done got %b expected 1 within %0d cycles", name, frame_done, 2 * P);
    end
  endtask

  // Called in the frame_done cycle; records the glyph of every digit of the next frame.
  task automatic capture(output logic [7:0][7:0] segs);
    logic [7:0] sel;
    segs = '0;
    cyc(2);
    for (int c = 0; c < P; c++) begin
      for (int k = 0; k < DIGITS; k++) begin
        sel = ~(8'd1 << k);
        if (dig_sel == sel) segs[k] = seg_out;
      end
      cyc(1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0][7:0] segs;
    logic [7:0]      want;
    logic [31:0]     r;
    int              n;

    // 1. reset state, scan order, frame period
    cyc(3);
    chk("reset_seg", {24'd0, seg_out}, 32'hFF);
    chk("reset_dig", {24'd0, dig_sel}, 32'hFF);
    chk("reset_fd", {31'd0, frame_done}, 32'd0);
    chk_en = 1'b1;
    rst = 1'b0;
    cyc(1);
    chk("first_dig", {24'd0, dig_sel}, 32'hFE);
    chk("first_seg", {24'd0, seg_out}, 32'hC0);
    for (int k = 1; k < DIGITS; k++) begin
      cyc(4);
      want = ~(8'd1 << k);
      chk($sformatf("scan_dig%0d", k), {24'd0, dig_sel}, {24'd0, want});
    end
    wait_fd("fd_first");
    n = 1;
    cyc(1);
    while (frame_done !== 1'b1 && n < 100) begin
      cyc(1);
      n++;
    end
    chk("fd_period", n, P);

`ifndef BIN2BCD_EN
    // 2. hex decode
    do_load(32'h000012AD, 8'h00);
    wait_fd("fd_decode");
    capture(segs);
    chk("dec_d0", {24'd0, segs[0]}, 32'hA1);
    chk("dec_d1", {24'd0, segs[1]}, 32'h88);
    chk("dec_d2", {24'd0, segs[2]}, 32'hA4);
    chk("dec_d3", {24'd0, segs[3]}, 32'hF9);
    for (int k = 4; k < 8; k++) chk($sformatf("dec_d%0d", k), {24'd0, segs[k]}, 32'hC0);

    // 3. leading-zero blanking with decimal point
    blank_lz = 1'b1;
    do_load(32'h00000050, 8'h02);
    wait_fd("fd_blank");
    capture(segs);
    chk("blk_d0", {24'd0, segs[0]}, 32'hC0);
    chk("blk_d1", {24'd0, segs[1]}, 32'h12);
    for (int k = 2; k < 8; k++) chk($sformatf("blk_d%0d", k), {24'd0, segs[k]}, 32'hFF);

    // 4. tear-free update
    blank_lz = 1'b0;
    do_load(32'h11111111, 8'h00);
    wait_fd("fd_tear_a");
    cyc(12);
    do_load(32'h22222222, 8'h00);
    chk("tear_mid", {24'd0, seg_out}, 32'hF9);
    wait_fd("fd_tear_b");
    capture(segs);
    for (int k = 0; k < 8; k++) chk($sformatf("tear_d%0d", k), {24'd0, segs[k]}, 32'hA4);
`endif

    // 5. reset mid-scan at index 5
    wait_fd("fd_midrst");
    cyc(1 + 5 * SCAN_DIV);
    rst = 1'b1;
    #1;
    chk("midrst_seg", {24'd0, seg_out}, 32'hFF);
    chk("midrst_dig", {24'd0, dig_sel}, 32'hFF);
    cyc(1);
    rst = 1'b0;
    cyc(1);
    chk("rel_dig", {24'd0, dig_sel}, 32'hFE);
    chk("rel_seg", {24'd0, seg_out}, 32'hC0);

`ifdef BIN2BCD_EN
    // 6. binary to BCD conversion and saturation
    do_load(32'd12345, 8'h00);
    wait_fd("fd_bcd_a");
    cyc(1);
    wait_fd("fd_bcd_b");
    capture(segs);
    chk("bcd_d0", {24'd0, segs[0]}, 32'h92);
    chk("bcd_d1", {24'd0, segs[1]}, 32'h99);
    chk("bcd_d2", {24'd0, segs[2]}, 32'hB0);
    chk("bcd_d3", {24'd0, segs[3]}, 32'hA4);
    chk("bcd_d4", {24'd0, segs[4]}, 32'hF9);
    for (int k = 5; k < 8; k++) chk($sformatf("bcd_d%0d", k), {24'd0, segs[k]}, 32'hC0);
    do_load(32'd100000000, 8'h00);
    wait_fd("fd_sat_a");
    cyc(1);
    wait_fd("fd_sat_b");
    capture(segs);
    for (int k = 0; k < 8; k++) chk($sformatf("sat_d%0d", k), {24'd0, segs[k]}, 32'h90);
`endif

    // Randomised traffic against the model
    for (int i = 0; i < 3000; i++) begin
      r = $urandom;
`ifdef BIN2BCD_EN
      r = r >> $urandom_range(0, 31);
`else
      r = r >> (4 * $urandom_range(0, 8));
`endif
      disp_data = r;
      dp_mask   = 8'($urandom);
      if ($urandom_range(0, 49) == 0) blank_lz = ~blank_lz;
      if ($urandom_range(0, 399) == 0) begin
        rst = 1'b1;
        cyc($urandom_range(1, 3));
        rst = 1'b0;
      end
      load = ($urandom_range(0, 5) == 0);
      if (load) $display("load data=%08h dp=%02h blank_lz=%0d t=%0t", disp_data, dp_mask, blank_lz, $time);
      cyc(1);
      load = 1'b0;
    end
    cyc(2);
    chk_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
